// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit-type codes in the two top flit
// bits, and the packet-framing state encoding used by the injection stage.
package noc_pkg;

  localparam int FLIT_W = 20;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pkt_state_t;

endpackage

// File: rtl/ni_sync_fifo.sv
// Synchronous FIFO with the head entry read combinationally.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/count only)
//   i_push        write i_wdata this cycle (caller guarantees room or a pop)
//   i_pop         retire the head entry this cycle (caller guarantees !o_empty)
//   i_wdata       write data
//   o_rdata       current head entry
//   o_full        count == DEPTH
//   o_empty       count == 0
//   o_count       occupancy, 0..DEPTH
module ni_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  // Storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers are log2(DEPTH) wide and wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ni_inject_queue.sv
// Network-interface injection stage. Captures the unstallable flit stream
// from the dataout buffer into a FIFO, forwards flits to the router under
// credit-based flow control, and checks head/tail framing on departure.
// Ports:
//   clk, RST     clock, synchronous active-high reset
//   in_flit      flit from the dataout buffer ([FLIT_W-1 -: 2] = type)
//   in_valid     in_flit valid; no backpressure, so a full FIFO drops it
//   credit_in    one-cycle pulse: router freed one input-buffer slot
//   out_flit     flit to the router, held between pops
//   out_valid    one-cycle pulse per forwarded flit
//   pkt_active   framing state is SEND
//   fifo_count   FIFO occupancy
//   overflow     sticky: a flit was dropped
//   fmt_err      sticky: framing violation on a departing flit
//   credit_err   sticky: credit_in arrived with the counter already full
// Optional build macro NI_INJECT_STATS_EN adds:
//   pkt_sent     16-bit wrapping count of departed tail/single flits
//   flit_drop    16-bit wrapping count of dropped flits
module ni_inject_queue #(
  parameter int FLIT_W  = noc_pkg::FLIT_W,
  parameter int DEPTH   = 32,
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [FLIT_W-1:0]      in_flit,
  input  logic                   in_valid,
  input  logic                   credit_in,
  output logic [FLIT_W-1:0]      out_flit,
  output logic                   out_valid,
  output logic                   pkt_active,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   fmt_err,
  output logic                   credit_err
`ifdef NI_INJECT_STATS_EN
  ,
  output logic [15:0]            pkt_sent,
  output logic [15:0]            flit_drop
`endif
);

  import noc_pkg::*;

  localparam int CW = $clog2(CREDITS + 1);

  logic [FLIT_W-1:0] w_rdata;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [1:0]        w_ftype;
  logic              w_fmt_viol;
  pkt_state_t        w_state_nxt;

  logic [CW-1:0]     r_credit_cnt;
  pkt_state_t        r_state;
  logic [FLIT_W-1:0] r_out_flit;
  logic              r_out_valid;
  logic              r_overflow;
  logic              r_fmt_err;
  logic              r_credit_err;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign w_pop   = !w_empty && (r_credit_cnt != '0);
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;
  assign w_ftype = w_rdata[FLIT_W-1 -: 2];

  ni_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (RST),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (in_flit),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Framing check on the flit leaving the FIFO this cycle. Violating flits
  // are still forwarded; only the sticky flag records them.
  always_comb begin
    w_state_nxt = r_state;
    w_fmt_viol  = 1'b0;
    if (w_pop) begin
      case (w_ftype)
        FT_HEAD: begin
          w_fmt_viol  = (r_state == ST_SEND);
          w_state_nxt = ST_SEND;
        end
        FT_SINGLE: begin
          w_fmt_viol  = (r_state == ST_SEND);
          w_state_nxt = ST_IDLE;
        end
        FT_TAIL: begin
          w_fmt_viol  = (r_state == ST_IDLE);
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_fmt_viol  = (r_state == ST_IDLE);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Credit counter: pop and credit in the same cycle cancel out; a credit
  // with nothing outstanding saturates and is flagged.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_credit_cnt <= CW'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      case ({w_pop, credit_in})
        2'b10: r_credit_cnt <= r_credit_cnt - CW'(1);
        2'b01: begin
          if (r_credit_cnt == CW'(CREDITS)) r_credit_err <= 1'b1;
          else                              r_credit_cnt <= r_credit_cnt + CW'(1);
        end
        default: r_credit_cnt <= r_credit_cnt;
      endcase
    end
  end

  // Output register stage: popped flit appears the cycle after the pop.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_fmt_err   <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      if (w_pop)      r_out_flit <= w_rdata;
      if (w_drop)     r_overflow <= 1'b1;
      if (w_fmt_viol) r_fmt_err  <= 1'b1;
    end
  end

`ifdef NI_INJECT_STATS_EN
  logic [15:0] r_pkt_sent;
  logic [15:0] r_flit_drop;

  // Tail and single both have type bit 1 set.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_pkt_sent  <= '0;
      r_flit_drop <= '0;
    end else begin
      if (w_pop && w_ftype[1]) r_pkt_sent  <= r_pkt_sent + 16'd1;
      if (w_drop)              r_flit_drop <= r_flit_drop + 16'd1;
    end
  end

  assign pkt_sent  = r_pkt_sent;
  assign flit_drop = r_flit_drop;
`endif

  assign out_flit   = r_out_flit;
  assign out_valid  = r_out_valid;
  assign pkt_active = (r_state == ST_SEND);
  assign overflow   = r_overflow;
  assign fmt_err    = r_fmt_err;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_ni_inject_queue.sv
module tb_ni_inject_queue;

  localparam int FW      = 20;
  localparam int DEPTH   = 32;
  localparam int CREDITS = 4;

  logic          clk = 1'b0;
  logic          RST;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          credit_in;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          pkt_active;
  logic [5:0]    fifo_count;
  logic          overflow;
  logic          fmt_err;
  logic          credit_err;

  ni_inject_queue #(
    .FLIT_W  (FW),
    .DEPTH   (DEPTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .credit_in  (credit_in),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .pkt_active (pkt_active),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .fmt_err    (fmt_err),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  // Reference model: a queue of waiting flits, an integer credit balance
  // and an "inside a packet" flag.
  logic [FW-1:0] mq[$];
  int            m_cred;
  logic          m_in_pkt;
  logic          m_ovf;
  logic          m_fmt;
  logic          m_cerr;
  logic          m_ovalid;
  logic [FW-1:0] m_oflit;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [FW-1:0] flit;
    logic          cin;
    logic          ov;
    logic [FW-1:0] of;
    int            cnt;
    logic          act;
    logic          ovf;
    logic          fmt;
    logic          cerr;
  } vec_t;

  vec_t tbl[16];

  int   due[$];
  int   first_out;
  logic pk_seen;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input int p);
    return {t, 18'(p)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic vld, input logic [FW-1:0] f,
                            input logic cin);
    logic          pop;
    logic [FW-1:0] pf;
    if (rst) begin
      mq.delete();
      m_cred = CREDITS; m_in_pkt = 1'b0;
      m_ovf = 1'b0; m_fmt = 1'b0; m_cerr = 1'b0;
      m_ovalid = 1'b0; m_oflit = '0;
      return;
    end
    pop = (mq.size() != 0) && (m_cred != 0);
    m_ovalid = pop;
    if (pop) begin
      pf = mq.pop_front();
      m_oflit = pf;
      case (pf[FW-1 -: 2])
        2'b01: begin if (m_in_pkt)  m_fmt = 1'b1; m_in_pkt = 1'b1; end
        2'b11: begin if (m_in_pkt)  m_fmt = 1'b1; m_in_pkt = 1'b0; end
        2'b10: begin if (!m_in_pkt) m_fmt = 1'b1; m_in_pkt = 1'b0; end
        default: begin if (!m_in_pkt) m_fmt = 1'b1; end
      endcase
    end
    m_cred = m_cred - (pop ? 1 : 0) + (cin ? 1 : 0);
    if (m_cred > CREDITS) begin
      m_cred = CREDITS;
      m_cerr = 1'b1;
    end
    if (vld) begin
      if (mq.size() < DEPTH) mq.push_back(f);
      else                   m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic rst, input logic vld, input logic [FW-1:0] f,
                      input logic cin);
    RST = rst; in_valid = vld; in_flit = f; credit_in = cin;
    @(posedge clk);
    model_edge(rst, vld, f, cin);
    #1;
    if (out_valid === 1'b1) n_out++;
    chk("out_valid",  32'(out_valid),  32'(m_ovalid));
    chk("out_flit",   32'(out_flit),   32'(m_oflit));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("pkt_active", 32'(pkt_active), 32'(m_in_pkt));
    chk("overflow",   32'(overflow),   32'(m_ovf));
    chk("fmt_err",    32'(fmt_err),    32'(m_fmt));
    chk("credit_err", 32'(credit_err), 32'(m_cerr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_flit = '0; credit_in = 1'b0;

    // Directed table: reset, a 3-flit packet, a single, an IDLE body flit,
    // credit return and credit saturation.
    tbl[0]  = '{1'b1, 1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 20'h40001, 1'b0, 1'b0, 20'h00000, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 20'h00002, 1'b0, 1'b1, 20'h40001, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 20'h80003, 1'b0, 1'b1, 20'h00002, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b1, 20'h80003, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 20'hC0004, 1'b0, 1'b0, 20'h80003, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b1, 20'hC0004, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 20'h00005, 1'b0, 1'b0, 20'hC0004, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 20'hC0004, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'hC0004, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b1, 20'h00005, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00005, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00005, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00005, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00005, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00005, 0, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].flit, tbl[i].cin);
      chk($sformatf("tbl%0d out_valid", i),  32'(out_valid),  32'(tbl[i].ov));
      chk($sformatf("tbl%0d out_flit", i),   32'(out_flit),   32'(tbl[i].of));
      chk($sformatf("tbl%0d fifo_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d pkt_active", i), 32'(pkt_active), 32'(tbl[i].act));
      chk($sformatf("tbl%0d overflow", i),   32'(overflow),   32'(tbl[i].ovf));
      chk($sformatf("tbl%0d fmt_err", i),    32'(fmt_err),    32'(tbl[i].fmt));
      chk($sformatf("tbl%0d credit_err", i), 32'(credit_err), 32'(tbl[i].cerr));
    end
    // Counter held at 4 after the saturating credit: exactly 4 flits leave.
    n_out = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, mk(2'b11, i), 1'b0);
    idle(6);
    chk("sat_credit_outs", 32'(n_out), 32'd4);

    // 30-flit packet with credits returned 2 cycles after each out_valid.
    step(1'b1, 1'b0, '0, 1'b0);
    n_out = 0; first_out = -1; pk_seen = 1'b0; due.delete();
    for (int k = 0; k < 70; k++) begin
      logic cin;
      logic [1:0] t;
      cin = 1'b0;
      if (due.size() != 0 && due[0] == k) begin
        cin = 1'b1;
        void'(due.pop_front());
      end
      t = (k == 0) ? 2'b01 : (k == 29) ? 2'b10 : 2'b00;
      step(1'b0, (k < 30), mk(t, k + 100), cin);
      if (out_valid === 1'b1) begin
        if (first_out < 0) first_out = k;
        due.push_back(k + 2);
      end
      if (pkt_active === 1'b1) pk_seen = 1'b1;
    end
    chk("pkt_outs", 32'(n_out), 32'd30);
    chk("pkt_first_latency_cycles", 32'(first_out + 1), 32'd2);
    chk("pkt_active_seen", 32'(pk_seen), 32'd1);
    chk("pkt_active_end", 32'(pkt_active), 32'd0);
    chk("pkt_fmt_err", 32'(fmt_err), 32'd0);
    chk("pkt_credit_err", 32'(credit_err), 32'd0);
    chk("pkt_overflow", 32'(overflow), 32'd0);

    // 30 flits with no credit return.
    step(1'b1, 1'b0, '0, 1'b0);
    n_out = 0;
    for (int k = 0; k < 30; k++)
      step(1'b0, 1'b1, mk((k == 0) ? 2'b01 : 2'b00, k), 1'b0);
    idle(5);
    chk("nocred_outs", 32'(n_out), 32'd4);
    chk("nocred_count", 32'(fifo_count), 32'd26);
    step(1'b0, 1'b0, '0, 1'b1);
    idle(4);
    chk("onecred_outs", 32'(n_out), 32'd5);
    chk("onecred_count", 32'(fifo_count), 32'd25);

    // Fill to the brim, then one drop.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 34; k++) step(1'b0, 1'b1, mk(2'b11, k), 1'b0);
    chk("fill34_overflow", 32'(overflow), 32'd0);
    chk("fill34_count", 32'(fifo_count), 32'd30);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, mk(2'b11, 200 + k), 1'b0);
    chk("fill36_overflow", 32'(overflow), 32'd0);
    chk("fill36_count", 32'(fifo_count), 32'd32);
    step(1'b0, 1'b1, mk(2'b11, 300), 1'b0);
    chk("drop_overflow", 32'(overflow), 32'd1);
    chk("drop_count", 32'(fifo_count), 32'd32);

    // Credit pulse right after reset.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("early_credit_err", 32'(credit_err), 32'd1);
    n_out = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, mk(2'b11, i), 1'b0);
    idle(6);
    chk("early_credit_outs", 32'(n_out), 32'd4);

    // Reset mid-packet with 10 flits queued.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 14; k++)
      step(1'b0, 1'b1, mk((k == 0) ? 2'b01 : 2'b00, k), 1'b0);
    chk("midpkt_count", 32'(fifo_count), 32'd10);
    chk("midpkt_active", 32'(pkt_active), 32'd1);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_pkt_active", 32'(pkt_active), 32'd0);
    n_out = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, mk(2'b11, i), 1'b0);
    idle(6);
    chk("rst_credit_outs", 32'(n_out), 32'd4);
    chk("rst_fmt_err", 32'(fmt_err), 32'd0);

    // Random traffic against the model, alternating light and heavy load.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      logic          r, v, c;
      logic [FW-1:0] f;
      int            pct;
      pct = ((k / 200) % 2 == 1) ? 90 : 40;
      r = ($urandom_range(0, 699) == 0);
      v = ($urandom_range(0, 99) < pct);
      c = ($urandom_range(0, 99) < 30);
      f = {2'($urandom), 18'($urandom)};
      step(r, v, f, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
